multimode_ff_reg: RTL and testbench
===================================

Name: multimode_ff_reg

Overview:
- Parametrised WIDTH-bit register bank. Each bit behaves as a D, JK, T or SR flip-flop, selected per cycle by a mode field.
- Also supports whole-word counting and shifting.
- Next-generation storage primitive for the lab datapaths. Replaces single-bit latch/flip-flop instances with one synchronous, resettable bank plus status outputs.

Parameters:
- WIDTH, 8, number of storage bits (>=2).
- RESET_VALUE, 0, value loaded into q on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  update enable; 0 = hold all state.
- mode  input  3  operation select (see Behaviour).
- a  input  WIDTH  D / J / T / S operand, per mode.
- b  input  WIDTH  K / R operand, per mode.
- ser_in  input  1  serial input bit for shift modes.
- err_clr  input  1  synchronous clear of sr_err.
- q  output  WIDTH  register state.
- q_n  output  WIDTH  bitwise complement of q.
- carry_out  output  1  one-cycle pulse on count wrap.
- ser_out  output  1  bit shifted out on the last shift.
- sr_err  output  1  sticky flag for illegal S=R=1.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, immediate, independent of clk):
  - q=RESET_VALUE, q_n=~RESET_VALUE.
  - carry_out=0, ser_out=0, sr_err=0.
- All other state changes occur on the rising edge of clk only.
- q_n is combinationally ~q at all times, including during reset.
- en=0: q and ser_out hold; carry_out=0 next cycle; err_clr still acts.
- en=1, per mode. Bit i = q[i]. Result is visible the cycle after the edge (1-cycle latency).
  - 000 HOLD: q unchanged.
  - 001 D: q <= a.
  - 010 JK, per bit:
    - J=a[i], K=b[i].
    - 00 hold, 10 set, 01 clear, 11 toggle.
  - 011 T: q <= q ^ a (bits with a[i]=1 toggle).
  - 100 SR, per bit:
    - S=a[i], R=b[i].
    - 10 set, 01 clear, 00 hold.
    - 11: bit holds and sr_err is set.
  - 101 COUNT:
    - q <= q+1, modulo 2^WIDTH.
    - carry_out=1 for exactly the cycle after the edge where q went all-ones -> 0; otherwise 0.
  - 110 SHL: q <= {q[WIDTH-2:0], ser_in}; ser_out <= old q[WIDTH-1].
  - 111 SHR: q <= {ser_in, q[WIDTH-1:1]}; ser_out <= old q[0].
- ser_out changes only in shift modes; otherwise it holds its last value.
- carry_out is registered and cleared on every edge that does not wrap.
- sr_err is sticky:
  - Set on any edge with en=1, mode=100 and (a & b) != 0.
  - Cleared on an edge with err_clr=1.
  - Simultaneous set and clear: set wins (sr_err stays 1).
- Operands a/b are ignored in HOLD, COUNT and shift modes.
- Reset asserted mid-operation (e.g. mid-count) aborts immediately to reset values. The first active edge after rst_n rises operates on RESET_VALUE.
- Implementation rule: a single clocked process with a case on mode. No gate-level latch loops or combinational feedback.

Test Plan:
- Reset and D load: rst_n=0 -> q=00, q_n=FF, flags 0. Release, en=1, mode=001, a=A5 -> q=A5, q_n=5A after one edge.
- JK and T: from q=F0, mode=010, a=3C, b=CC -> q=3C (bits J1K1 toggle, J1K0 set, J0K1 clear, J0K0 hold). Then mode=011, a=0F -> q=33.
- SR illegal pair: from q=00, mode=100, a=81, b=01 -> q=80, sr_err=1. Then err_clr=1 with mode=100, a=01, b=01 -> sr_err stays 1 (set wins). Then err_clr=1 with mode=000 -> sr_err=0.
- Count wrap: load FE, mode=101 for 3 edges -> q=FF, 00, 01. carry_out=1 only in the cycle q=00.
- Shifts: load 81, mode=110, ser_in=0 -> q=02, ser_out=1. Then mode=111, ser_in=1 -> q=81, ser_out=0.
- Enable and async reset: en=0 with mode=101 for 4 edges -> q unchanged, carry_out=0. Assert rst_n low between edges while counting at 7F -> q=00 immediately, without waiting for an edge.

Source files
------------

// File: rtl/multimode_ff_reg.sv
`default_nettype none
// ============================================================================
// multimode_ff_reg : WIDTH-bit bank of D/JK/T/SR flip-flops with count/shift
// Revision 1.0
// ============================================================================
module multimode_ff_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ser_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             carry_out,
  output logic             ser_out,
  output logic             sr_err
);

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_D     = 3'b001;
  localparam logic [2:0] MODE_JK    = 3'b010;
  localparam logic [2:0] MODE_T     = 3'b011;
  localparam logic [2:0] MODE_SR    = 3'b100;
  localparam logic [2:0] MODE_COUNT = 3'b101;
  localparam logic [2:0] MODE_SHL   = 3'b110;
  localparam logic [2:0] MODE_SHR   = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic             r_ser;
  logic             r_err;

  // S=R=1 bits are excluded from both set and clear, so they hold.
  logic [WIDTH-1:0] w_sr_set;
  logic [WIDTH-1:0] w_sr_clr;
  logic             w_sr_illegal;

  assign w_sr_set     = a & ~b;
  assign w_sr_clr     = b & ~a;
  assign w_sr_illegal = en && (mode == MODE_SR) && ((a & b) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q     <= RESET_VALUE;
      r_carry <= 1'b0;
      r_ser   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_carry <= 1'b0;
      if (en) begin
        case (mode)
          MODE_HOLD:  r_q <= r_q;
          MODE_D:     r_q <= a;
          MODE_JK:    r_q <= (a & ~r_q) | (~b & r_q);
          MODE_T:     r_q <= r_q ^ a;
          MODE_SR:    r_q <= (r_q & ~w_sr_clr) | w_sr_set;
          MODE_COUNT: begin
            r_q     <= r_q + 1'b1;
            r_carry <= &r_q;
          end
          MODE_SHL: begin
            r_q   <= {r_q[WIDTH-2:0], ser_in};
            r_ser <= r_q[WIDTH-1];
          end
          MODE_SHR: begin
            r_q   <= {ser_in, r_q[WIDTH-1:1]};
            r_ser <= r_q[0];
          end
          default:    r_q <= r_q;
        endcase
      end
      // Set takes priority over a simultaneous clear.
      r_err <= w_sr_illegal | (r_err & ~err_clr);
    end
  end

  assign q         = r_q;
  assign q_n       = ~r_q;
  assign carry_out = r_carry;
  assign ser_out   = r_ser;
  assign sr_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_multimode_ff_reg.sv
`default_nettype none
// ============================================================================
// tb_multimode_ff_reg : directed vector table, corner sequences, random vs model
// Revision 1.0
// ============================================================================
module tb_multimode_ff_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ser_in;
  logic         err_clr;
  logic [W-1:0] q;
  logic [W-1:0] q_n;
  logic         carry_out;
  logic         ser_out;
  logic         sr_err;

  int n_checks = 0;
  int n_pass   = 0;

  multimode_ff_reg #(.WIDTH(W), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b),
    .ser_in(ser_in), .err_clr(err_clr), .q(q), .q_n(q_n),
    .carry_out(carry_out), .ser_out(ser_out), .sr_err(sr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         en;
    logic [2:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         si;
    logic         ec;
    logic [W-1:0] q;
    logic         c;
    logic         so;
    logic         err;
  } vec_t;

  vec_t vt[$];

  // Reference state, updated from the behavioural rules rather than the RTL.
  int m_q;
  bit m_c, m_so, m_err;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag, input int eq, input bit ec, input bit es, input bit ee);
    chk({tag, " q"}, int'(q), eq);
    chk({tag, " q_n"}, int'(q_n), (~eq) & 8'hFF);
    chk({tag, " carry_out"}, int'(carry_out), int'(ec));
    chk({tag, " ser_out"}, int'(ser_out), int'(es));
    chk({tag, " sr_err"}, int'(sr_err), int'(ee));
  endtask

  task automatic drive(input bit e, input logic [2:0] m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input bit si, input bit ec);
    en = e; mode = m; a = av; b = bv; ser_in = si; err_clr = ec;
  endtask

  task automatic model_step();
    int nq;
    bit illegal;
    nq = m_q;
    illegal = 0;
    m_c = 0;
    if (en) begin
      case (int'(mode))
        1: nq = int'(a);
        2, 4: begin
          nq = 0;
          for (int i = 0; i < W; i++) begin
            bit qi, s, r;
            qi = m_q[i]; s = a[i]; r = b[i];
            if (mode == 3'd2) begin
              if (s && r)  qi = !qi;
              else if (s)  qi = 1;
              else if (r)  qi = 0;
            end else begin
              if (s && r)  illegal = 1;
              else if (s)  qi = 1;
              else if (r)  qi = 0;
            end
            if (qi) nq += (1 << i);
          end
        end
        3: nq = m_q ^ int'(a);
        5: begin
          nq = (m_q + 1) % 256;
          m_c = (m_q == 255);
        end
        6: begin
          m_so = (m_q / 128) % 2;
          nq = ((m_q * 2) % 256) + int'(ser_in);
        end
        7: begin
          m_so = m_q % 2;
          nq = (m_q / 2) + (ser_in ? 128 : 0);
        end
        default: nq = m_q;
      endcase
    end
    m_q = nq;
    if (illegal) m_err = 1;
    else if (err_clr) m_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 3'd0, '0, '0, 0, 0);
    m_q = 0; m_c = 0; m_so = 0; m_err = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic add(input bit e, input logic [2:0] m, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input bit si, input bit ec, input logic [W-1:0] eq, input bit c, input bit so, input bit er);
    vec_t v;
    v.en = e; v.mode = m; v.a = av; v.b = bv; v.si = si; v.ec = ec;
    v.q = eq; v.c = c; v.so = so; v.err = er;
    vt.push_back(v);
  endtask

  initial begin
    // en mode a b ser_in err_clr | q carry ser_out sr_err
    add(1, 3'b001, 8'hA5, 8'h00, 0, 0, 8'hA5, 0, 0, 0);
    add(1, 3'b001, 8'hF0, 8'h00, 0, 0, 8'hF0, 0, 0, 0);
    add(1, 3'b010, 8'h3C, 8'hCC, 0, 0, 8'h3C, 0, 0, 0);
    add(1, 3'b011, 8'h0F, 8'h00, 0, 0, 8'h33, 0, 0, 0);
    add(1, 3'b001, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1, 3'b100, 8'h81, 8'h01, 0, 0, 8'h80, 0, 0, 1);
    add(1, 3'b100, 8'h01, 8'h01, 0, 1, 8'h80, 0, 0, 1);
    add(1, 3'b000, 8'hFF, 8'hFF, 0, 1, 8'h80, 0, 0, 0);
    add(1, 3'b001, 8'hFE, 8'h00, 0, 0, 8'hFE, 0, 0, 0);
    add(1, 3'b101, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 0, 0);
    add(1, 3'b101, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    add(1, 3'b101, 8'h00, 8'h00, 0, 0, 8'h01, 0, 0, 0);
    add(1, 3'b001, 8'h81, 8'h00, 0, 0, 8'h81, 0, 0, 0);
    add(1, 3'b110, 8'h00, 8'h00, 0, 0, 8'h02, 0, 1, 0);
    add(1, 3'b111, 8'h00, 8'h00, 1, 0, 8'h81, 0, 0, 0);
    add(1, 3'b001, 8'hFF, 8'h00, 0, 0, 8'hFF, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(0, 3'b101, 8'h00, 8'h00, 0, 0, 8'hFF, 0, 0, 0);
    add(1, 3'b101, 8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0);
    add(0, 3'b101, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1, 3'b001, 8'h80, 8'h00, 0, 0, 8'h80, 0, 0, 0);
    add(1, 3'b110, 8'h00, 8'h00, 1, 0, 8'h01, 0, 1, 0);
    add(1, 3'b001, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 0);
    add(1, 3'b100, 8'h02, 8'h02, 0, 0, 8'h00, 0, 1, 1);
    add(0, 3'b100, 8'h04, 8'h04, 0, 1, 8'h00, 0, 1, 0);

    do_reset();
    #1 check_all("reset", 8'h00, 0, 0, 0);

    foreach (vt[i]) begin
      drive(vt[i].en, vt[i].mode, vt[i].a, vt[i].b, vt[i].si, vt[i].ec);
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), int'(vt[i].q), vt[i].c, vt[i].so, vt[i].err);
    end

    // Async reset mid-count: must take effect between edges.
    drive(1, 3'b001, 8'h7E, 8'h00, 0, 0);
    @(posedge clk); #1;
    drive(1, 3'b101, 8'h00, 8'h00, 0, 0);
    @(posedge clk); #1;
    chk("count to 7F", int'(q), 8'h7F);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst q", int'(q), 8'h00);
    chk("async rst q_n", int'(q_n), 8'hFF);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first edge after rst", int'(q), 8'h01);

    // Randomised run against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
            1'($urandom), ($urandom_range(0, 5) == 0));
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_q, m_c, m_so, m_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
